vga_sync_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. Produces the pixel strobe, horizontal/vertical counters, sync pulses and the visible-area flag. Sits directly upstream of the text data generator and the RGB output mux: `pixel_x`/`pixel_y`/`video_on` feed the character/row address logic, and `hsync`/`vsync` drive the connector pins.

---
 rtl/vga_sync_gen.sv | 69 ++++++
 tb/tb_vga_sync_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60Hz VGA timing (pixel strobe, counters, syncs, visible flag) from the system clock
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(HD + HF + HR + HB - 1);
  localparam logic [9:0] V_LAST = 10'(VD + VF + VR + VB - 1);
  localparam logic [9:0] HS_LO = 10'(HD + HF);
  localparam logic [9:0] HS_HI = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_LO = 10'(VD + VF);
  localparam logic [9:0] VS_HI = 10'(VD + VF + VR - 1);
  localparam logic [9:0] H_VIS = 10'(HD);
  localparam logic [9:0] V_VIS = 10'(VD);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic h_end, v_end;
  always_comb begin
    p_tick = div_q == DIV_LAST;
    h_end = h_q == H_LAST;
    v_end = v_q == V_LAST;
    div_d = p_tick ? '0 : div_q + DW'(1);
    h_d = p_tick ? (h_end ? 10'd0 : h_q + 10'd1) : h_q;
    v_d = (p_tick && h_end) ? (v_end ? 10'd0 : v_q + 10'd1) : v_q;
    // syncs come from the next counter values so they line up with pixel_x/pixel_y
    hsync_d = !(h_d >= HS_LO && h_d <= HS_HI);
    vsync_d = !(v_d >= VS_LO && v_d <= VS_HI);
    pixel_x = h_q;
    pixel_y = v_q;
    video_on = h_q < H_VIS && v_q < V_VIS;
    hsync = hsync_q;
    vsync = vsync_q;
    frame_tick = p_tick && h_end && v_end;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: arithmetic reference model for default and small-parameter instances, random resets
module tb_vga_sync_gen;
  logic clk = 0;
  always #5 clk = ~clk;
  logic ra, rb;
  logic apt, avo, ahs, avs, aft, bpt, bvo, bhs, bvs, bft;
  logic [9:0] ax, ay, bx, by;
  int checks = 0, errors = 0;
  int na = 0, nb = 0;
  bit va = 0, vb = 0;
  vga_sync_gen dut_a (.clk(clk), .reset(ra), .p_tick(apt), .pixel_x(ax), .pixel_y(ay),
    .video_on(avo), .hsync(ahs), .vsync(avs), .frame_tick(aft));
  vga_sync_gen #(.CLK_DIV(2), .HD(8), .HF(2), .HR(3), .HB(3), .VD(4), .VF(1), .VR(1), .VB(2)) dut_b (
    .clk(clk), .reset(rb), .p_tick(bpt), .pixel_x(bx), .pixel_y(by),
    .video_on(bvo), .hsync(bhs), .vsync(bvs), .frame_tick(bft));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  // expected outputs after n clk cycles since reset, packed {p_tick,x,y,video_on,hsync,vsync,frame_tick}
  function automatic logic [24:0] model(input int n, input int cd, input int hd, input int hf,
      input int hr, input int hb, input int vd, input int vf, input int vr, input int vb);
    int ht, vt, p, x, y;
    logic pt;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    p = n / cd;
    x = p % ht;
    y = (p / ht) % vt;
    pt = (n % cd) == cd - 1;
    return {pt, 10'(x), 10'(y), x < hd && y < vd, !(x >= hd + hf && x < hd + hf + hr),
      !(y >= vd + vf && y < vd + vf + vr), pt && x == ht - 1 && y == vt - 1};
  endfunction
  always @(posedge clk) begin
    if (ra) begin na <= 0; va <= 1; end else na <= na + 1;
    if (rb) begin nb <= 0; vb <= 1; end else nb <= nb + 1;
  end
  always @(negedge clk) begin
    if (va) chk("model_a", int'({apt, ax, ay, avo, ahs, avs, aft}), int'(model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33)));
    if (vb) chk("model_b", int'({bpt, bx, by, bvo, bhs, bvs, bft}), int'(model(nb, 2, 8, 2, 3, 3, 4, 1, 1, 2)));
  end
  task automatic seq_a;
    ra = 1;
    repeat (3) @(negedge clk);
    chk("a_rst_x", int'(ax), 0);
    chk("a_rst_y", int'(ay), 0);
    chk("a_rst_syncs", int'({ahs, avs}), 3);
    chk("a_rst_vo_pt_ft", int'({avo, apt, aft}), 4);
    ra = 0;
    repeat (3) @(negedge clk);
    chk("a_first_ptick", int'(apt), 1);
    chk("a_x_before_tick", int'(ax), 0);
    @(negedge clk);
    chk("a_x_after_tick", int'(ax), 1);
    repeat (2619) @(negedge clk);
    chk("a_x655", int'(ax), 655);
    chk("a_hs_at655", int'(ahs), 1);
    @(negedge clk);
    chk("a_x656", int'(ax), 656);
    chk("a_hs_at656", int'(ahs), 0);
    repeat (383) @(negedge clk);
    chk("a_hs_last_low", int'({ax, ahs}), 751 * 2);
    @(negedge clk);
    chk("a_hs_rise", int'({ax, ahs}), 752 * 2 + 1);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(100, 6000)) @(negedge clk);
      ra = 1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      ra = 0;
    end
    repeat (7000) @(negedge clk);
  endtask
  task automatic seq_b;
    int k;
    rb = 1;
    repeat (2) @(negedge clk);
    rb = 0;
    repeat (255) @(negedge clk);
    chk("b_ft_first", int'({bft, bx, by}), (1 << 20) | (15 << 10) | 7);
    @(negedge clk);
    chk("b_after_ft", int'({bft, bx, by}), 0);
    k = 0;
    while (!bft && k < 1000) begin @(negedge clk); k++; end
    k = 0;
    do begin @(negedge clk); k++; end while (!bft && k < 1000);
    chk("b_frame_period", k, 256);
    k = 0;
    while (!(bx == 11 && by == 5) && k < 1000) begin @(negedge clk); k++; end
    chk("b_mid_syncs_low", int'({bx, by, bhs, bvs}), (11 << 12) | (5 << 2));
    rb = 1;
    @(negedge clk);
    rb = 0;
    chk("b_mid_rst", int'({bx, by, bhs, bvs, bpt}), 6);
    repeat (3) @(negedge clk);
    chk("b_restart_x", int'(bx), 1);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      rb = 1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rb = 0;
    end
    repeat (800) @(negedge clk);
  endtask
  initial begin
    fork
      seq_a();
      seq_b();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
